pim_job_scheduler: RTL

Command-driven sequencer for the PIM array that sits between the RISC-V-facing register decode and the weight, activation and result buffers. It queues CPU commands (load weights, run, drain results), each targeting one of four macros. It then generates the per-row weight strobes, the activation launch, the compute wait and the result capture, and paces result readout. Macro steering is a single 2-bit select applied to the existing demux/mux fabric.

---
 rtl/pim_sched_pkg.sv | 12 +
 rtl/pim_job_scheduler_if.sv | 32 +++
 rtl/pim_cmd_fifo.sv | 44 ++++
 rtl/pim_job_scheduler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pim_sched_pkg.sv
// pim_sched_pkg: op encodings, FSM states, idle word-line address and the 13-bit command record
package pim_sched_pkg;
  typedef enum logic [1:0] {OP_LOAD_W = 2'd0, OP_RUN = 2'd1, OP_DRAIN = 2'd2, OP_NOP = 2'd3} op_e;
  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_ACT, S_COMPUTE, S_CAPTURE, S_DRAIN} state_e;
  localparam int unsigned WL_IDLE_ADDR = 288;
  localparam int unsigned CMD_W = 13;
  typedef struct packed {
    op_e op;
    logic [1:0] macro;
    logic [8:0] rows;
  } cmd_t;
endpackage

// File: rtl/pim_job_scheduler_if.sv
// pim_job_scheduler_if: command push, buffer handshakes, strobes and status of the scheduler; slave = scheduler side, master = CPU/fabric side
interface pim_job_scheduler_if;
  logic i_cmd_valid;
  logic o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [1:0] i_cmd_macro;
  logic [8:0] i_cmd_rows;
  logic i_wb_ready;
  logic i_ab_ready;
  logic i_rd_ack;
  logic i_err_clr;
  logic [1:0] o_macro_sel;
  logic o_weight_out_en;
  logic [8:0] o_WL_address;
  logic o_activation_out_en;
  logic o_result_in_en;
  logic [7:0] o_result_word;
  logic o_busy;
  logic o_valid;
  logic o_err;
  logic [31:0] o_perf_cycles;
  modport slave (
    input i_cmd_valid, i_cmd_op, i_cmd_macro, i_cmd_rows, i_wb_ready, i_ab_ready, i_rd_ack, i_err_clr,
    output o_cmd_ready, o_macro_sel, o_weight_out_en, o_WL_address, o_activation_out_en, o_result_in_en,
    output o_result_word, o_busy, o_valid, o_err, o_perf_cycles
  );
  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_macro, i_cmd_rows, i_wb_ready, i_ab_ready, i_rd_ack, i_err_clr,
    input o_cmd_ready, o_macro_sel, o_weight_out_en, o_WL_address, o_activation_out_en, o_result_in_en,
    input o_result_word, o_busy, o_valid, o_err, o_perf_cycles
  );
endinterface

// File: rtl/pim_cmd_fifo.sv
// pim_cmd_fifo: DEPTH x W sync FIFO (i_clk, i_rst async high; i_push/i_wdata in, i_pop/o_rdata out, o_full/o_empty from registered count)
module pim_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0] cnt_t;
  logic [W-1:0] mem_q [DEPTH];
  ptr_t wr_q, wr_d, rd_q, rd_d;
  cnt_t cnt_q, cnt_d;
  logic do_push, do_pop;
  assign o_full = cnt_q == cnt_t'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign o_rdata = mem_q[rd_q];
  always_comb begin
    do_push = i_push & ~o_full;
    do_pop = i_pop & ~o_empty;
    wr_d = wr_q + ptr_t'(do_push);
    rd_d = rd_q + ptr_t'(do_pop);
    cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) if (do_push) mem_q[wr_q] <= i_wdata;
endmodule

// File: rtl/pim_job_scheduler.sv
// pim_job_scheduler: queued LOAD_W/RUN/DRAIN sequencer for 4 PIM macros (i_clk, i_rst async high, bus = pim_job_scheduler_if.slave); PIM_SCHED_PERF_EN builds the busy-cycle counter
module pim_job_scheduler
  import pim_sched_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int WL_ROWS = WL_IDLE_ADDR,
  parameter int COMPUTE_CYCLES = 4,
  parameter int RESULT_WORDS = 256
) (
  input logic i_clk,
  input logic i_rst,
  pim_job_scheduler_if.slave bus
);
  localparam int CCW = $clog2(COMPUTE_CYCLES + 1);
  state_e state_q, state_d;
  cmd_t head;
  logic empty, full, pop, busy, pending, err_set;
  logic [1:0] macro_q, macro_d;
  logic [8:0] rows_q, rows_d, r_q, r_d, addr_q, addr_d;
  logic [CCW-1:0] cnt_q, cnt_d;
  logic [7:0] word_q, word_d;
  logic we_q, we_d, act_q, act_d, res_q, res_d, valid_q, valid_d, err_q, err_d;
  pim_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(CMD_W)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (bus.i_cmd_valid),
    .i_wdata({bus.i_cmd_op, bus.i_cmd_macro, bus.i_cmd_rows}),
    .i_pop  (pop),
    .o_rdata(head),
    .o_full (full),
    .o_empty(empty)
  );
  assign busy = (state_q != S_IDLE) | ~empty;
  // a capture strobe still in flight counts as an undrained result
  assign pending = valid_q | res_q;
  always_comb begin
    state_d = state_q;
    macro_d = macro_q;
    rows_d = rows_q;
    r_d = r_q;
    cnt_d = cnt_q;
    word_d = word_q;
    we_d = 1'b0;
    addr_d = 9'(WL_ROWS);
    act_d = 1'b0;
    res_d = 1'b0;
    valid_d = pending;
    err_set = 1'b0;
    pop = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        macro_d = head.macro;
        rows_d = head.rows;
        r_d = '0;
        case (head.op)
          OP_LOAD_W: begin
            err_set = head.rows == '0 || head.rows > 9'(WL_ROWS);
            state_d = err_set ? S_IDLE : S_WLOAD;
          end
          OP_RUN: begin
            err_set = pending;
            state_d = pending ? S_IDLE : S_ACT;
          end
          OP_DRAIN: begin
            err_set = ~pending;
            state_d = pending ? S_DRAIN : S_IDLE;
            word_d = '0;
          end
          default: ;
        endcase
      end
      S_WLOAD: if (bus.i_wb_ready) begin
        we_d = 1'b1;
        addr_d = r_q;
        r_d = r_q + 9'd1;
        state_d = (r_q == rows_q - 9'd1) ? S_IDLE : S_WLOAD;
      end
      S_ACT: if (bus.i_ab_ready) begin
        act_d = 1'b1;
        cnt_d = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + CCW'(1);
        state_d = (cnt_q == CCW'(COMPUTE_CYCLES - 1)) ? S_CAPTURE : S_COMPUTE;
      end
      S_CAPTURE: begin
        res_d = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: if (bus.i_rd_ack) begin
        if (word_q == 8'(RESULT_WORDS - 1)) begin
          word_d = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          word_d = word_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set | (err_q & ~bus.i_err_clr);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      macro_q <= '0;
      rows_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      we_q <= 1'b0;
      addr_q <= 9'(WL_ROWS);
      act_q <= 1'b0;
      res_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      macro_q <= macro_d;
      rows_q <= rows_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      we_q <= we_d;
      addr_q <= addr_d;
      act_q <= act_d;
      res_q <= res_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign bus.o_cmd_ready = ~full;
  assign bus.o_macro_sel = macro_q;
  assign bus.o_weight_out_en = we_q;
  assign bus.o_WL_address = addr_q;
  assign bus.o_activation_out_en = act_q;
  assign bus.o_result_in_en = res_q;
  assign bus.o_result_word = word_q;
  assign bus.o_busy = busy;
  assign bus.o_valid = valid_q;
  assign bus.o_err = err_q;
`ifdef PIM_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (busy && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign bus.o_perf_cycles = perf_q;
`else
  assign bus.o_perf_cycles = '0;
`endif
endmodule
